// File: rtl/mux_8to1_arbiter.sv
// Round-robin arbiter that owns an 8:1 mux: picks one requester, drives sel/en_n,
// and forces a release after MAX_HOLD consecutive granted cycles.
//
// state | meaning
// IDLE  | no owner, en_n=1; evaluates req each edge (also the dead cycle after a release)
// GRANT | winner owns the mux; hold_cnt counts granted cycles
module mux_8to1_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en_n,
    output logic [7:0] grant,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [2:0] winner;
    logic       found;
    logic [2:0] idx;

    // Scan ptr+1 .. ptr+8 so the last winner gets lowest priority.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            hold_cnt <= 8'd0;
            sel      <= 3'd0;
            en_n     <= 1'b1;
            grant    <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 8'h00) begin
                        state    <= GRANT;
                        sel      <= winner;
                        grant    <= 8'(1) << winner;
                        en_n     <= 1'b0;
                        hold_cnt <= 8'd1;
                    end
                end
                GRANT: begin
                    if (!req[sel] || hold_cnt == HOLD_LIMIT) begin
                        state    <= IDLE;
                        ptr      <= sel;
                        grant    <= 8'h00;
                        en_n     <= 1'b1;
                        hold_cnt <= 8'd0;
                        // A simultaneous drop of req wins over the limit: no timeout then.
                        timeout  <= req[sel];
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_8to1_arbiter.sv
// Directed bench for mux_8to1_arbiter: three instances (MAX_HOLD 16, 4, 1) on one clock
// and reset, outputs sampled on the falling edge.
module tb_mux_8to1_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req16 = 8'h00, req4 = 8'h00, req1 = 8'h00;
    logic [2:0] sel16, sel4, sel1;
    logic       en16, en4, en1;
    logic [7:0] grant16, grant4, grant1;
    logic       to16, to4, to1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mux_8to1_arbiter #(.MAX_HOLD(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .sel(sel16),
        .en_n(en16), .grant(grant16), .timeout(to16));
    mux_8to1_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .sel(sel4),
        .en_n(en4), .grant(grant4), .timeout(to4));
    mux_8to1_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .sel(sel1),
        .en_n(en1), .grant(grant1), .timeout(to1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic exp_grant(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic e, input logic t, input int k);
        chk({tag, "_grant"}, g, 8'(1) << k);
        chk({tag, "_sel"}, 8'(s), 8'(k));
        chk({tag, "_en_n"}, 8'(e), 8'd0);
        chk({tag, "_timeout"}, 8'(t), 8'd0);
    endtask

    task automatic exp_idle(input string tag, input logic [7:0] g, input logic e,
                            input logic t, input logic t_exp);
        chk({tag, "_grant"}, g, 8'h00);
        chk({tag, "_en_n"}, 8'(e), 8'd1);
        chk({tag, "_timeout"}, 8'(t), 8'(t_exp));
    endtask

    task automatic inv(input string tag, input logic [7:0] g, input logic [2:0] s, input logic e);
        n_total++;
        assert ($onehot0(g) && (e == (g == 8'h00)) && (e || g == (8'(1) << s))) n_pass++;
        else $error("FAIL %s: observed grant=%0h sel=%0d en_n=%0b expected one-hot grant matching sel and en_n",
                    tag, g, s, e);
    endtask

    always @(negedge clk) begin
        inv("inv16", grant16, sel16, en16);
        inv("inv4", grant4, sel4, en4);
        inv("inv1", grant1, sel1, en1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sel", 8'(sel16), 8'd0);
        exp_idle("rst", grant16, en16, to16, 1'b0);
        rst_n = 1'b1;

        // All requesting: 0..7 then 0, 16 cycles each, timeout in each dead cycle
        @(negedge clk);
        req16 = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                exp_grant("rr_ff", grant16, sel16, en16, to16, g % 8);
            end
            @(negedge clk);
            exp_idle("rr_ff_dead", grant16, en16, to16, 1'b1);
        end
        req16 = 8'h00;
        @(negedge clk);
        exp_idle("rr_ff_quiet", grant16, en16, to16, 1'b0);

        // Bits 2 and 5, each drops after 3 granted cycles (ptr=0 -> 2 first)
        req16 = 8'h24;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_grant("norm2", grant16, sel16, en16, to16, 2);
        end
        req16 = 8'h20;
        @(negedge clk);
        exp_idle("norm2_rel", grant16, en16, to16, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_grant("norm5", grant16, sel16, en16, to16, 5);
        end
        req16 = 8'h00;
        @(negedge clk);
        exp_idle("norm5_rel", grant16, en16, to16, 1'b0);
        chk("norm5_rel_sel_hold", 8'(sel16), 8'd5);

        // req[6] drops on the 16th granted cycle: normal release, no timeout
        req16 = 8'h40;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_grant("edge6", grant16, sel16, en16, to16, 6);
        end
        req16 = 8'h00;
        @(negedge clk);
        exp_idle("edge6_rel", grant16, en16, to16, 1'b0);
        @(negedge clk);
        exp_idle("edge6_after", grant16, en16, to16, 1'b0);

        // Asynchronous reset during a grant on 4 (ptr=6 -> 7,0,..,4)
        req16 = 8'h10;
        repeat (2) begin
            @(negedge clk);
            exp_grant("pre_rst4", grant16, sel16, en16, to16, 4);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_idle("async_rst", grant16, en16, to16, 1'b0);
        chk("async_rst_sel", 8'(sel16), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req16 = 8'h11;
        @(negedge clk);
        exp_grant("post_rst0", grant16, sel16, en16, to16, 0);
        req16 = 8'h10;
        @(negedge clk);
        exp_idle("post_rst_rel", grant16, en16, to16, 1'b0);
        @(negedge clk);
        exp_grant("post_rst4", grant16, sel16, en16, to16, 4);
        req16 = 8'h00;
        @(negedge clk);
        exp_idle("post_rst4_rel", grant16, en16, to16, 1'b0);

        // Sole requester 3 with MAX_HOLD=4: 4 granted, 1 idle with timeout
        req4 = 8'h08;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                exp_grant("hold4", grant4, sel4, en4, to4, 3);
            end
            @(negedge clk);
            exp_idle("hold4_dead", grant4, en4, to4, 1'b1);
        end
        req4 = 8'h00;
        @(negedge clk);
        exp_idle("hold4_quiet", grant4, en4, to4, 1'b0);

        // MAX_HOLD=1 with bits 0 and 7: single-cycle grants alternating 0,7,0
        req1 = 8'h81;
        @(negedge clk);
        exp_grant("hold1_a", grant1, sel1, en1, to1, 0);
        @(negedge clk);
        exp_idle("hold1_a_to", grant1, en1, to1, 1'b1);
        @(negedge clk);
        exp_grant("hold1_b", grant1, sel1, en1, to1, 7);
        @(negedge clk);
        exp_idle("hold1_b_to", grant1, en1, to1, 1'b1);
        @(negedge clk);
        exp_grant("hold1_c", grant1, sel1, en1, to1, 0);
        req1 = 8'h00;
        @(negedge clk);
        exp_idle("hold1_c_rel", grant1, en1, to1, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_8to1_arbiter.md
MUX_8TO1_ARBITER -- requirements
Module: mux_8to1_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of consecutive cycles one requester may hold the grant; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: request lines; req[i] high means requester i wants the shared 8:1 mux output.
REQ-005 The block SHALL have port sel, output, 3 bits: select code for the 8:1 mux, equal to the index of the current winner.
REQ-006 The block SHALL have port en_n, output, 1 bit: active-low mux enable; 0 only while a grant is active.
REQ-007 The block SHALL have port grant, output, 8 bits: one-hot grant vector, bit i set only when requester i owns the mux.
REQ-008 The block SHALL have port timeout, output, 1 bit: one-cycle pulse marking a forced release at MAX_HOLD.
REQ-009 All outputs SHALL be driven directly from registers, with no combinational path from req to any output.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE: en_n=1, grant=8'h00, sel holds its last value, and the hold counter is 0.
REQ-012 IDLE->GRANT SHALL occur at the first edge where req != 0; grant, en_n=0 and sel become valid in the cycle after req is sampled (latency 1 cycle).
REQ-013 Winner selection SHALL be round-robin: scan indices ptr+1, ptr+2, ..., ptr+8 (mod 8) and take the first index with req set, where ptr is the last winner.
REQ-014 ptr SHALL update to the winner's index when the grant is released, and at no other time.
REQ-015 In GRANT: grant is one-hot at the winner, sel=winner, en_n=0, and all three SHALL be stable for the entire grant.
REQ-016 The 8-bit hold counter SHALL load 1 on entry to GRANT and increment by 1 on each following GRANT cycle; it SHALL never wrap.
REQ-017 Release: GRANT->IDLE SHALL occur at the edge where req[winner]==0 is sampled (normal release) or hold counter==MAX_HOLD (forced release).
REQ-018 On forced release, timeout SHALL be 1 for exactly the first IDLE cycle; in all other cycles timeout SHALL be 0.
REQ-019 If req[winner] drops in the same cycle the counter reaches MAX_HOLD, the release SHALL be treated as normal (timeout stays 0).
REQ-020 After every release the FSM SHALL spend at least one cycle in IDLE with en_n=1 (dead cycle), even if requests are pending.
REQ-021 Requests from non-winners during GRANT SHALL be ignored until the next IDLE evaluation; a requester needs no latching and must hold req high to be served.
REQ-022 With MAX_HOLD=1, each grant SHALL last exactly one cycle, followed by a forced release with a timeout pulse while req[winner] stays high.
REQ-023 A sole persistent requester SHALL be re-granted after the dead cycle, giving the pattern MAX_HOLD cycles granted, then 1 cycle idle.

Reset
REQ-024 While rst_n=0 (asynchronous): state=IDLE, ptr=7, hold counter=0, sel=3'd0, en_n=1, grant=8'h00, timeout=0.
REQ-025 ptr=7 at reset SHALL give req[0] first priority after reset.
REQ-026 Reset asserted mid-grant SHALL drop en_n to 1 and grant to 0 immediately, without waiting for a clock edge.
REQ-027 The first grant after reset release SHALL follow REQ-013 using ptr=7.

Verification
REQ-028 Reset, then req=8'hFF held: grants SHALL follow the order 0,1,2,...,7,0, each lasting MAX_HOLD=16 cycles, with timeout pulsing after each grant and one idle cycle between grants.
REQ-029 req=8'h24 (bits 2 and 5), each requester dropping req 3 cycles after its grant: sel=2 for 3 cycles, idle, then sel=5 for 3 cycles; timeout stays 0.
REQ-030 Only req[3] held high, MAX_HOLD=4: the bench SHALL see grant=8'h08 for 4 cycles, then 1 idle cycle with timeout=1, repeating.
REQ-031 req[6] drops exactly on the 16th grant cycle (MAX_HOLD=16): release SHALL occur with timeout=0 (REQ-019).
REQ-032 rst_n pulsed low during a grant on sel=4: en_n=1 and grant=0 SHALL occur asynchronously; after reset release, req=8'h11 SHALL grant index 0 first.
REQ-033 A bench assertion SHALL check throughout every test that grant is zero or one-hot, en_n==(grant==0), and sel matches the grant index while en_n=0.
